// File: rtl/zap_pfb_pkg.sv
// Shared types for the instruction prefetch buffer: controller states and
// the FIFO entry layout handed to the fetch stage.
package zap_pfb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        abort;
        logic [29:0] word_pc;
    } pfb_entry_t;

endpackage

// File: rtl/zap_pfb_fifo.sv
// Synchronous FIFO of prefetched entries; pointers carry an extra wrap bit
// so full and empty are distinguishable and count is a plain subtraction.
module zap_pfb_fifo
    import zap_pfb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  pfb_entry_t              i_push_data,
    input  logic                    i_pop,
    output pfb_entry_t              o_head,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pfb_entry_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign o_count = wr_ptr - rd_ptr;
    assign o_empty = (wr_ptr == rd_ptr);
    assign full    = (o_count == CW'(DEPTH));
    assign do_push = i_push && !full && !i_flush;
    assign do_pop  = i_pop && !o_empty && !i_flush;

    // Head reads as zero when empty so the consumer never sees stale storage.
    assign o_head  = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/zap_instr_prefetch_buffer.sv
// Prefetch controller: issues word requests to the I-cache, buffers returned
// words and abort flags, and presents them to fetch as a valid stream.
module zap_instr_prefetch_buffer
    import zap_pfb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  logic        i_stall,
    output logic        o_code_stb,
    output logic [31:0] o_code_addr,
    input  logic        i_code_ack,
    input  logic [31:0] i_code_data,
    input  logic        i_code_err,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic        o_instr_abort,
    output logic [31:0] o_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state;
    logic            stb;
    logic [29:0]     addr_w;
    logic [29:0]     saved_w;
    logic [29:0]     flush_w;
    logic            flush_pc_unused;
    logic            push;
    logic            pop;
    logic            empty;
    logic            can_req;
    logic [CW-1:0]   count;
    pfb_entry_t      push_data;
    pfb_entry_t      head;

    assign flush_w         = i_flush_pc[31:2];
    assign flush_pc_unused = ^i_flush_pc[1:0];
    assign can_req         = (count < CW'(DEPTH));

    // A word is kept only when it answers a live FETCH request and no flush lands.
    assign push      = (state == FETCH) && stb && i_code_ack && !i_flush;
    assign pop       = !empty && !i_stall;
    assign push_data = '{instr: i_code_data, abort: i_code_err, word_pc: addr_w};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            stb     <= 1'b0;
            addr_w  <= '0;
            saved_w <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_flush) begin
                        state  <= FETCH;
                        addr_w <= flush_w;
                    end
                end
                FETCH: begin
                    if (i_flush) begin
                        // An outstanding bus cycle cannot be withdrawn; wait it out.
                        if (stb && !i_code_ack) begin
                            state   <= DRAIN;
                            saved_w <= flush_w;
                        end else begin
                            stb    <= 1'b0;
                            addr_w <= flush_w;
                        end
                    end else if (stb) begin
                        if (i_code_ack) begin
                            stb <= 1'b0;
                            if (i_code_err) state  <= HALT;
                            else            addr_w <= addr_w + 30'd1;
                        end
                    end else if (can_req) begin
                        stb <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (i_flush) saved_w <= flush_w;
                    if (i_code_ack) begin
                        stb    <= 1'b0;
                        state  <= FETCH;
                        addr_w <= i_flush ? flush_w : saved_w;
                    end
                end
                HALT: begin
                    if (i_flush) begin
                        state  <= FETCH;
                        addr_w <= flush_w;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    zap_pfb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_flush),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_empty     (empty),
        .o_count     (count)
    );

    assign o_code_stb    = stb;
    assign o_code_addr   = {addr_w, 2'b00};
    assign o_valid       = !empty;
    assign o_instruction = head.instr;
    assign o_instr_abort = head.abort;
    assign o_pc          = {head.word_pc, 2'b00};

endmodule

// File: tb/tb_zap_instr_prefetch_buffer.sv
// Scoreboard bench: stimulus queues expected requests and entries, a bus
// responder answers requests, and a monitor checks every consumed entry.
module tb_zap_instr_prefetch_buffer;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        i_stall;
    logic        o_code_stb;
    logic [31:0] o_code_addr;
    logic        i_code_ack;
    logic [31:0] i_code_data;
    logic        i_code_err;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic        o_instr_abort;
    logic [31:0] o_pc;

    always #5 i_clk = ~i_clk;

    zap_instr_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_flush       (i_flush),
        .i_flush_pc    (i_flush_pc),
        .i_stall       (i_stall),
        .o_code_stb    (o_code_stb),
        .o_code_addr   (o_code_addr),
        .i_code_ack    (i_code_ack),
        .i_code_data   (i_code_data),
        .i_code_err    (i_code_err),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_instr_abort (o_instr_abort),
        .o_pc          (o_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        abort;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          total = 0;
    int          bad = 0;
    int          acks_left = 0;
    int          acks_given = 0;
    int          bus_delay = 1;
    logic [31:0] err_addr = 32'h1;
    logic        data_ovr_en = 1'b0;
    logic [31:0] data_ovr = 32'h0;
    logic        chk_lat = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic abort);
        exp_t e;
        e.pc = pc;
        e.instr = word_of(pc);
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        @(negedge i_clk);
        i_flush = 1'b1;
        i_flush_pc = pc;
        @(negedge i_clk);
        i_flush = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", nm, exp_q.size());
        end
    endtask

    task automatic do_reset();
        acks_left = 0;
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        exp_q.delete();
        req_q.delete();
    endtask

    // Bus responder: acks after bus_delay cycles of strobe, checking the address.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        i_code_ack = 1'b0;
        i_code_err = 1'b0;
        i_code_data = 32'h0;
        forever begin
            @(negedge i_clk);
            i_code_ack = 1'b0;
            i_code_err = 1'b0;
            if (!o_code_stb || !i_reset_n) begin
                wait_cnt = 0;
            end else if (acks_left > 0) begin
                if (wait_cnt < bus_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    acks_left--;
                    acks_given++;
                    if (req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_unexpected: got addr %h want none", o_code_addr);
                    end else begin
                        chk("req_addr", o_code_addr, req_q.pop_front());
                    end
                    i_code_ack = 1'b1;
                    i_code_err = (o_code_addr == err_addr);
                    i_code_data = data_ovr_en ? data_ovr : word_of(o_code_addr);
                    data_ovr_en = 1'b0;
                end
            end
        end
    end

    // Monitor: every consumed head must match the next expected entry.
    initial begin
        logic last_ack;
        exp_t e;
        last_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_reset_n) begin
                if (chk_lat && last_ack) chk("ack_to_valid", 32'(o_valid), 32'd1);
                if (o_valid && !i_stall && !i_flush) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected: got pc %h instr %h want none", o_pc, o_instruction);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_pc", o_pc, e.pc);
                        chk("pop_instr", o_instruction, e.instr);
                        chk("pop_abort", 32'(o_instr_abort), 32'(e.abort));
                    end
                end
            end
            last_ack = i_code_ack && !i_flush && i_reset_n;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int base;
        i_reset_n = 1'b0;
        i_flush = 1'b0;
        i_flush_pc = 32'h0;
        i_stall = 1'b0;
        cyc(3);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_stb", 32'(o_code_stb), 32'd0);
        chk("rst_addr", o_code_addr, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_abort", 32'(o_instr_abort), 32'd0);
        i_reset_n = 1'b1;
        cyc(5);
        chk("idle_no_stb", 32'(o_code_stb), 32'd0);

        // Streaming with no stall, plus ack-to-valid latency
        chk_lat = 1'b1;
        req_q.push_back(32'h100); req_q.push_back(32'h104); req_q.push_back(32'h108);
        push_exp(32'h100, 1'b0); push_exp(32'h104, 1'b0); push_exp(32'h108, 1'b0);
        acks_left = 3;
        do_flush(32'h100);
        wait_empty("stream");
        chk_lat = 1'b0;
        do_reset();

        // Fill to full under stall, then release
        i_stall = 1'b1;
        base = acks_given;
        req_q.push_back(32'h100); req_q.push_back(32'h104);
        req_q.push_back(32'h108); req_q.push_back(32'h10C);
        acks_left = 5;
        do_flush(32'h100);
        cyc(30);
        chk("full_acks", 32'(acks_given - base), 32'd4);
        chk("full_no_stb", 32'(o_code_stb), 32'd0);
        req_q.push_back(32'h110);
        push_exp(32'h100, 1'b0); push_exp(32'h104, 1'b0); push_exp(32'h108, 1'b0);
        push_exp(32'h10C, 1'b0); push_exp(32'h110, 1'b0);
        i_stall = 1'b0;
        wait_empty("full");
        do_reset();

        // Instruction abort halts issue until a flush
        err_addr = 32'h208;
        req_q.push_back(32'h200); req_q.push_back(32'h204); req_q.push_back(32'h208);
        push_exp(32'h200, 1'b0); push_exp(32'h204, 1'b0); push_exp(32'h208, 1'b1);
        acks_left = 3;
        do_flush(32'h200);
        wait_empty("abort");
        seen = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_code_stb) seen++;
        end
        chk("halt_no_stb", 32'(seen), 32'd0);
        err_addr = 32'h1;
        req_q.push_back(32'h300);
        push_exp(32'h300, 1'b0);
        acks_left = 1;
        do_flush(32'h300);
        wait_empty("halt_exit");
        do_reset();

        // Flush during a pending request: drained word must be discarded
        req_q.push_back(32'h380);
        do_flush(32'h380);
        n = 0;
        while (!o_code_stb && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain_pre_stb", 32'(o_code_stb), 32'd1);
        do_flush(32'h3C0);
        do_flush(32'h400);
        chk("drain_stb_held", 32'(o_code_stb), 32'd1);
        chk("drain_addr_held", o_code_addr, 32'h380);
        data_ovr = 32'hDEADBEEF;
        data_ovr_en = 1'b1;
        req_q.push_back(32'h400);
        push_exp(32'h400, 1'b0);
        acks_left = 2;
        wait_empty("drain");
        do_reset();

        // Address wrap at the top of memory
        req_q.push_back(32'hFFFF_FFF8); req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0);
        push_exp(32'hFFFF_FFF8, 1'b0); push_exp(32'hFFFF_FFFC, 1'b0); push_exp(32'h0, 1'b0);
        acks_left = 3;
        do_flush(32'hFFFF_FFF8);
        wait_empty("wrap");
        do_reset();

        // Reset while the FIFO holds three words and a request is outstanding
        i_stall = 1'b1;
        base = acks_given;
        req_q.push_back(32'h500); req_q.push_back(32'h504); req_q.push_back(32'h508);
        acks_left = 3;
        do_flush(32'h500);
        n = 0;
        while (acks_given - base < 3 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        cyc(2);
        chk("midrst_valid_before", 32'(o_valid), 32'd1);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_stb", 32'(o_code_stb), 32'd0);
        chk("midrst_addr", o_code_addr, 32'h0);
        chk("midrst_pc", o_pc, 32'h0);
        i_reset_n = 1'b1;
        i_stall = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_code_stb || o_valid) seen++;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
